// File: rtl/fft_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fft_sched_pkg                                              |
// | Description : Shared state encoding, width helpers and the state type    |
// |               for the radix-2 DIT FFT stage scheduler.                   |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fft_sched_pkg;

  // State encoding, 2 bits wide.
  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_RUN   = 2'd1;
  localparam logic [1:0] ENC_DRAIN = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    RUN   = ENC_RUN,
    DRAIN = ENC_DRAIN,
    DONE  = ENC_DONE
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Width of the stage index: must hold 0..N_LOG2, never narrower than 1 bit.
  function automatic int stage_w(input int n_log2);
    return (clog2(n_log2 + 1) < 1) ? 1 : clog2(n_log2 + 1);
  endfunction

  // Width of the butterfly / twiddle index: N/2 values.
  function automatic int idx_w(input int n_log2);
    return n_log2 - 1;
  endfunction

  // Width of the drain counter: must hold 0..PIPE_LAT.
  function automatic int drain_w(input int pipe_lat);
    return (clog2(pipe_lat + 1) < 1) ? 1 : clog2(pipe_lat + 1);
  endfunction

endpackage : fft_sched_pkg
`default_nettype wire

// File: rtl/fft_stage_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : fft_stage_sched_if                                         |
// | Description : Host handshake plus RAM / twiddle ROM strobes of the FFT   |
// |               stage scheduler.                                           |
// | Ports       : i_start (host request), o_busy, o_done, o_stage,           |
// |               o_rd_en, o_rd_addr_a/b, o_tw_idx, o_wr_en, o_wr_addr_a/b   |
// |               master = scheduler, slave = host/datapath side             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface fft_stage_sched_if #(
  parameter int N_LOG2 = 5
);
  import fft_sched_pkg::*;

  localparam int STAGE_W = stage_w(N_LOG2);
  localparam int IDX_W   = idx_w(N_LOG2);

  logic                i_start;
  logic                o_busy;
  logic                o_done;
  logic [STAGE_W-1:0]  o_stage;
  logic                o_rd_en;
  logic [N_LOG2-1:0]   o_rd_addr_a;
  logic [N_LOG2-1:0]   o_rd_addr_b;
  logic [IDX_W-1:0]    o_tw_idx;
  logic                o_wr_en;
  logic [N_LOG2-1:0]   o_wr_addr_a;
  logic [N_LOG2-1:0]   o_wr_addr_b;

  modport master (
    input  i_start,
    output o_busy, o_done, o_stage,
    output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
    output o_wr_en, o_wr_addr_a, o_wr_addr_b
  );

  modport slave (
    output i_start,
    input  o_busy, o_done, o_stage,
    input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
    input  o_wr_en, o_wr_addr_a, o_wr_addr_b
  );

endinterface : fft_stage_sched_if
`default_nettype wire

// File: rtl/fft_wb_delay.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_wb_delay                                               |
// | Description : DEPTH-stage shift register carrying {valid, addr_a,        |
// |               addr_b} from read issue to write-back.                     |
// | Ports       : clk, rst_n (async active-low clear),                       |
// |               in_valid/in_addr_a/in_addr_b -> out_valid/out_addr_a/b     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fft_wb_delay #(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_valid,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b
);

  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    addr_a_q [DEPTH];
  logic [AW-1:0]    addr_b_q [DEPTH];

  // Clearing on reset drops every in-flight write, so none survive an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_a_q[i] <= '0;
        addr_b_q[i] <= '0;
      end
    end else begin
      vld[0]      <= in_valid;
      addr_a_q[0] <= in_addr_a;
      addr_b_q[0] <= in_addr_b;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]      <= vld[i-1];
        addr_a_q[i] <= addr_a_q[i-1];
        addr_b_q[i] <= addr_b_q[i-1];
      end
    end
  end

  assign out_valid  = vld[DEPTH-1];
  assign out_addr_a = addr_a_q[DEPTH-1];
  assign out_addr_b = addr_b_q[DEPTH-1];

endmodule : fft_wb_delay
`default_nettype wire

// File: rtl/fft_stage_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_stage_sched                                            |
// | Description : Sequencer for an in-place radix-2 DIT FFT with one shared  |
// |               butterfly. Issues one A/B read pair plus twiddle index per |
// |               cycle, stage by stage, and the matching write-back         |
// |               addresses PIPE_LAT cycles later.                           |
// | Ports       : i_clk, i_rst_n (async active-low),                         |
// |               bus (fft_stage_sched_if.master): start/busy/done/stage,    |
// |               read strobe + addresses + twiddle, write strobe + addresses|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fft_stage_sched
  import fft_sched_pkg::*;
#(
  parameter int N_LOG2   = 5,
  parameter int PIPE_LAT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fft_stage_sched_if.master  bus
);

  localparam int AW = N_LOG2;
  localparam int SW = stage_w(N_LOG2);
  localparam int JW = idx_w(N_LOG2);
  localparam int DW = drain_w(PIPE_LAT);

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] stage;
  logic [JW-1:0] bfly;
  logic [DW-1:0] drain_cnt;

  logic last_bfly;
  logic last_drain;
  logic last_stage;
  logic rd_en;
  logic busy;
  logic done;

  assign last_bfly  = (bfly == J_LAST);
  assign last_drain = (drain_cnt == D_LAST);
  assign last_stage = (stage == S_LAST);

  // ---------------------------------------------------------------- FSM --
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (last_bfly) begin
          state_nx = DRAIN;
        end
      end
      // Holding reads off for PIPE_LAT cycles lets the stage's last write
      // land before the next stage reads the same words.
      DRAIN: begin
        busy = 1'b1;
        if (last_drain) begin
          state_nx = last_stage ? DONE : RUN;
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- counters --
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage     <= '0;
      bfly      <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            stage <= '0;
            bfly  <= '0;
          end
        end
        RUN: begin
          // Wraps to 0 after the last butterfly, ready for the next stage.
          bfly      <= bfly + JW'(1);
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (last_drain && !last_stage) begin
            stage <= stage + SW'(1);
          end
        end
        DONE: begin
          stage <= '0;
        end
        default: begin
          stage <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------- address generation --
  // Butterfly j of stage s pairs words that differ only in bit s:
  // the low s bits of j give the position inside the group, the rest the
  // group, which is spread out by one extra bit to make room for bit s.
  logic [AW-1:0] bfly_ext;
  logic [AW-1:0] half;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [SW-1:0] tw_shift;
  logic [JW-1:0] tw_idx;

  assign bfly_ext = AW'(bfly);
  assign half     = AW'(1) << stage;
  assign pos      = bfly_ext & (half - AW'(1));
  assign grp      = bfly_ext >> stage;
  assign addr_a   = (grp << (stage + SW'(1))) | pos;
  assign addr_b   = addr_a + half;
  assign tw_shift = S_LAST - stage;
  assign tw_idx   = JW'(pos << tw_shift);

  // Addresses are forced to 0 when idle so the bus is quiet outside RUN.
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;

  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? addr_b : '0;

  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_stage     = stage;
  assign bus.o_rd_en     = rd_en;
  assign bus.o_rd_addr_a = rd_addr_a;
  assign bus.o_rd_addr_b = rd_addr_b;
  assign bus.o_tw_idx    = rd_en ? tw_idx : '0;

  // ---------------------------------------------------------- write-back --
  fft_wb_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (AW)
  ) u_wb_delay (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .in_valid   (rd_en),
    .in_addr_a  (rd_addr_a),
    .in_addr_b  (rd_addr_b),
    .out_valid  (bus.o_wr_en),
    .out_addr_a (bus.o_wr_addr_a),
    .out_addr_b (bus.o_wr_addr_b)
  );

endmodule : fft_stage_sched
`default_nettype wire
